// File: rtl/led_frame_writer.sv
// Two-wire LED bus frame transmitter: FIFO-fed bytes, start/stop framing,
// four bus slots per bit, one slot per CLK_DIV system clocks.
module led_frame_writer #(
    parameter int CLK_DIV   = 12,
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] value,
    input  logic             last,
    output logic             ready,
    output logic             d_clk,
    output logic             d_out,
    output logic             busy,
    output logic             done
);

    localparam int CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int AW      = $clog2(DEPTH);
    localparam int BW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int FIRST_I = (LSB_FIRST != 0) ? 0 : WIDTH - 1;
    localparam int LAST_I  = (LSB_FIRST != 0) ? WIDTH - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        HOLD,
        STOP
    } state_e;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    state_e           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [BW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             last_q, last_d;
    logic             d_clk_q, d_clk_d;
    logic             d_out_q, d_out_d;
    logic [WIDTH:0]   mem_q [DEPTH];

    logic             tick;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             load;
    logic [WIDTH:0]   head;
    logic [BW-1:0]    nxt_idx;

    assign tick  = (cnt_q == CW'(CLK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign ready = !full;
    assign push  = valid && !full;
    assign head  = mem_q[rd_q[AW-1:0]];
    assign wr_d  = wr_q + {{AW{1'b0}}, push};
    assign rd_d  = rd_q + {{AW{1'b0}}, pop};

    assign nxt_idx = (LSB_FIRST != 0) ? idx_q + 1'b1 : idx_q - 1'b1;

    assign busy  = (state_q != IDLE) || !empty;
    assign d_clk = d_clk_q;
    assign d_out = d_out_q;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        last_d  = last_q;
        d_clk_d = d_clk_q;
        d_out_d = d_out_q;
        load    = 1'b0;
        done    = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    d_clk_d = 1'b1;
                    d_out_d = 1'b1;
                    if (!empty) begin
                        state_d = START;
                        d_out_d = 1'b0;
                    end
                end
                START: load = 1'b1;
                BIT: begin
                    if (slot_q != 2'd3) begin
                        slot_d  = slot_q + 2'd1;
                        d_clk_d = (slot_q != 2'd2);
                    end else if (idx_q != BW'(LAST_I)) begin
                        idx_d   = nxt_idx;
                        slot_d  = 2'd0;
                        d_clk_d = 1'b0;
                        d_out_d = sh_q[nxt_idx];
                    end else if (last_q) begin
                        state_d = STOP;
                        d_clk_d = 1'b1;
                        d_out_d = 1'b0;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = HOLD;
                        d_clk_d = 1'b0;
                        d_out_d = 1'b0;
                    end
                end
                HOLD: load = !empty;
                STOP: begin
                    state_d = IDLE;
                    d_clk_d = 1'b1;
                    d_out_d = 1'b1;
                    done    = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        // Every path into a new byte goes through here: pop and drive slot 0.
        if (load) begin
            state_d = BIT;
            sh_d    = head[WIDTH-1:0];
            last_d  = head[WIDTH];
            idx_d   = BW'(FIRST_I);
            slot_d  = 2'd0;
            d_clk_d = 1'b0;
            d_out_d = head[FIRST_I];
        end
    end

    assign pop = load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= IDLE;
            slot_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            last_q  <= 1'b0;
            d_clk_q <= 1'b1;
            d_out_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            d_clk_q <= d_clk_d;
            d_out_q <= d_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {last, value};
    end

endmodule

// File: tb/tb_led_frame_writer.sv
// Bench for led_frame_writer: bus slots are captured per tick and decoded
// back into framed bytes, then compared with the bytes the bench pushed.
module tb_led_frame_writer;

    localparam int CLK_DIV = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [7:0] value;
    logic       last;
    logic       ready0, d_clk0, d_out0, busy0, done0;
    logic       ready1, d_clk1, d_out1, busy1, done1;

    always #5 clk = ~clk;

    led_frame_writer #(
        .CLK_DIV(CLK_DIV), .DEPTH(4), .WIDTH(8), .LSB_FIRST(1)
    ) u_lsb (
        .clk(clk), .rst_n(rst_n), .valid(valid), .value(value),
        .last(last), .ready(ready0), .d_clk(d_clk0), .d_out(d_out0),
        .busy(busy0), .done(done0)
    );

    led_frame_writer #(
        .CLK_DIV(CLK_DIV), .DEPTH(4), .WIDTH(8), .LSB_FIRST(0)
    ) u_msb (
        .clk(clk), .rst_n(rst_n), .valid(valid), .value(value),
        .last(last), .ready(ready1), .d_clk(d_clk1), .d_out(d_out1),
        .busy(busy1), .done(done1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slot-level capture, written only by the monitor processes.
    int         phase = 0;
    bit         rst_seen = 1'b0;
    int         cyc = 0;
    int         clr_req = 0;
    int         clr_seen = 0;
    int         align_err = 0;
    int         dcnt0 = 0, dcnt1 = 0;
    int         st0 = 0, st1 = 0;
    int         fclk0 = 0, fclk1 = 0;
    logic [1:0] prev0 = 2'b11, prev1 = 2'b11;
    logic [1:0] now0, now1;
    logic [1:0] slots0[$];
    logic [1:0] slots1[$];
    logic [8:0] exp_q[$];

    always @(posedge clk) begin
        rst_seen <= rst_n;
        if (!rst_n) phase <= 0;
        else phase <= (phase == CLK_DIV - 1) ? 0 : phase + 1;
    end

    always @(negedge clk) begin
        cyc++;
        if (clr_req != clr_seen) begin
            slots0.delete();
            slots1.delete();
            clr_seen = clr_req;
        end
        now0 = {d_clk0, d_out0};
        now1 = {d_clk1, d_out1};
        if (rst_seen) begin
            if (phase == 0) begin
                slots0.push_back(now0);
                slots1.push_back(now1);
            end else if (now0 != prev0 || now1 != prev1) begin
                align_err++;
            end
            if (prev0 == 2'b11 && now0 == 2'b10) st0 = cyc;
            if (prev0 == 2'b10 && now0 == 2'b11) fclk0 = cyc - st0;
            if (prev1 == 2'b11 && now1 == 2'b10) st1 = cyc;
            if (prev1 == 2'b10 && now1 == 2'b11) fclk1 = cyc - st1;
        end
        if (done0) dcnt0++;
        if (done1) dcnt1++;
        prev0 = now0;
        prev1 = now1;
    end

    // Protocol decoder: start (1,0), bits (0,b)(1,b)(1,b)(0,b),
    // hold (0,0) while the next slot keeps d_clk low, stop (1,0) then idle.
    task automatic decode(input string tag, input logic [1:0] s[$],
                          input bit lsb, input int nframes,
                          output int holds);
        int         i;
        int         frames;
        int         nbit;
        int         fbytes;
        bit         ok;
        bit         in_f;
        logic       b;
        logic [7:0] byt;
        logic [8:0] got[$];
        i = 0; frames = 0; nbit = 0; fbytes = 0;
        ok = 1'b1; holds = 0; byt = '0; b = 1'b0;
        while (ok && i < s.size()) begin
            if (s[i] == 2'b11) begin
                i++;
            end else if (s[i] != 2'b10) begin
                ok = 1'b0;
            end else begin
                frames++; i++; fbytes = 0; nbit = 0; in_f = 1'b1;
                while (ok && in_f) begin
                    if (i + 1 >= s.size()) begin
                        ok = 1'b0;
                    end else if (s[i] == 2'b10) begin
                        if (nbit != 0 || fbytes == 0) ok = 1'b0;
                        else got[got.size()-1][8] = 1'b1;
                        if (s[i+1] != 2'b11) ok = 1'b0;
                        i++; in_f = 1'b0;
                    end else if (s[i] == 2'b00 && !s[i+1][1]) begin
                        holds++; i++;
                    end else if (i + 3 >= s.size()) begin
                        ok = 1'b0;
                    end else begin
                        b = s[i][0];
                        if (s[i] != {1'b0, b} || s[i+1] != {1'b1, b} ||
                            s[i+2] != {1'b1, b} || s[i+3] != {1'b0, b})
                            ok = 1'b0;
                        if (lsb) byt[nbit] = b;
                        else byt[7-nbit] = b;
                        nbit++; i += 4;
                        if (nbit == 8) begin
                            got.push_back({1'b0, byt});
                            nbit = 0; fbytes++;
                        end
                    end
                end
            end
        end
        chk({tag, "_proto"}, ok, 1);
        chk({tag, "_frames"}, frames, nframes);
        chk({tag, "_nbytes"}, got.size(), exp_q.size());
        for (int j = 0; j < got.size() && j < exp_q.size(); j++)
            chk({tag, "_byte"}, got[j], exp_q[j]);
    endtask

    int base0, base1;

    task automatic begin_test();
        exp_q.delete();
        clr_req++;
        repeat (2) @(negedge clk);
        base0 = dcnt0;
        base1 = dcnt1;
    endtask

    task automatic finish_test(input string tag, input int n,
                               output int holds);
        int k;
        int h1;
        k = 0;
        while ((dcnt0 < base0 + n || dcnt1 < base1 + n) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done0"}, dcnt0 - base0, n);
        chk({tag, "_done1"}, dcnt1 - base1, n);
        repeat (3 * CLK_DIV) @(negedge clk);
        decode({tag, "_lsb"}, slots0, 1'b1, n, holds);
        decode({tag, "_msb"}, slots1, 1'b0, n, h1);
        chk({tag, "_holds_eq"}, h1, holds);
    endtask

    task automatic push(input logic [7:0] v, input bit l);
        int n;
        n = 0;
        while (!ready0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ready0) begin
            chk("ready_wait", ready0, 1);
        end else begin
            valid = 1'b1; value = v; last = l;
            exp_q.push_back({l, v});
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    int h;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; value = '0; last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d_clk", d_clk0, 1);
        chk("rst_d_out", d_out0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", ready0, 1);
        chk("rst_done", done0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        begin_test();
        push(8'hA5, 1'b1);
        finish_test("a5", 1, h);
        chk("a5_clks_lsb", fclk0, 34 * CLK_DIV);
        chk("a5_clks_msb", fclk1, 34 * CLK_DIV);
        chk("a5_holds", h, 0);
        chk("a5_busy", busy0, 0);

        begin_test();
        push(8'h40, 1'b0);
        push(8'hC0, 1'b0);
        push(8'hFF, 1'b1);
        finish_test("three", 1, h);
        chk("three_clks_lsb", fclk0, 98 * CLK_DIV);
        chk("three_clks_msb", fclk1, 98 * CLK_DIV);
        chk("three_holds", h, 0);

        begin_test();
        push(8'h12, 1'b0);
        repeat (200 * CLK_DIV) @(negedge clk);
        chk("uf_hold_bus", {d_clk0, d_out0}, 2'b00);
        chk("uf_busy", busy0, 1);
        push(8'h34, 1'b1);
        finish_test("underrun", 1, h);
        chk("uf_holds_range", (h >= 150 && h <= 205), 1);

        begin_test();
        for (int j = 0; j < 6; j++) begin
            chk("full_ready", ready0, (j < 4));
            chk("full_ready_msb", ready1, (j < 4));
            valid = 1'b1;
            value = 8'(8'h10 + j);
            last = (j == 3);
            if (j < 4) exp_q.push_back({(j == 3), 8'(8'h10 + j)});
            @(negedge clk);
        end
        valid = 1'b0;
        chk("full_ready_after", ready0, 0);
        finish_test("full", 1, h);
        chk("full_ready_end", ready0, 1);

        begin_test();
        push(8'h5A, 1'b0);
        push(8'h3C, 1'b0);
        push(8'h99, 1'b1);
        repeat (560) @(negedge clk);
        chk("mid_busy", busy0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_bus", {d_clk0, d_out0}, 2'b11);
        chk("mid_rst_bus_msb", {d_clk1, d_out1}, 2'b11);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_ready", ready0, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        begin_test();
        push(8'hC3, 1'b1);
        finish_test("after_rst", 1, h);
        chk("after_rst_clks", fclk0, 34 * CLK_DIV);

        begin_test();
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        finish_test("two", 2, h);

        for (int r = 0; r < 3; r++) begin
            int nf;
            int len;
            int g;
            begin_test();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                len = $urandom_range(1, 5);
                for (int b = 0; b < len; b++) begin
                    g = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 600)
                                                    : $urandom_range(0, 20);
                    repeat (g) @(negedge clk);
                    push(8'($urandom), (b == len - 1));
                end
            end
            finish_test("rand", nf, h);
        end

        chk("tick_align", align_err, 0);
        chk("end_busy", busy0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
